// File: rtl/cvp14_pkg.sv
// Shared definitions for the vector memory sequencer: lane geometry, FSM states, grant flag.
// Latency: n/a (types, constants and a pure lane-select function only).
// Backpressure: n/a.
package cvp14_pkg;

    localparam int LANE_W    = 16;                    // bits per lane / memory word
    localparam int NUM_LANES = 16;                    // lanes per vector
    localparam int VEC_W     = LANE_W * NUM_LANES;    // 256-bit vector
    localparam int CNT_W     = $clog2(NUM_LANES);     // lane index / burst count width
    localparam int ADDR_W    = 16;                    // memory word address width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        IF_CAP = 3'd2,
        LS_RD  = 3'd3,
        LS_CAP = 3'd4,
        LS_WR  = 3'd5,
        DONE   = 3'd6
    } vmem_state_e;

    // Which requester received the most recent grant; drives round-robin tie break.
    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_VEC   = 1'b1
    } gnt_e;

    // Lane idx of a packed vector; lane k occupies bits [16k+15:16k].
    function automatic logic [LANE_W-1:0] lane_of(
        input logic [VEC_W-1:0] vec,
        input logic [CNT_W-1:0] idx
    );
        return vec[int'(idx) * LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/vmem_lane_mux.sv
// Selects one 16-bit lane out of a 256-bit vector.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   vec_dat  [255:0] in  : source vector
//   sel      [3:0]   in  : lane index
//   lane_dat [15:0]  out : selected lane
module vmem_lane_mux
    import cvp14_pkg::*;
(
    input  logic [VEC_W-1:0]  vec_dat,
    input  logic [CNT_W-1:0]  sel,
    output logic [LANE_W-1:0] lane_dat
);

    always_comb begin
        lane_dat = lane_of(vec_dat, sel);
    end

endmodule

// File: rtl/vec_mem_seq.sv
// Arbitrates one instruction-fetch port and one vector load/store port onto a single word memory.
// Latency: fetch if_gnt->if_valid 2 cycles; burst of N words takes N+2 (load) / N+1 (store) cycles to ls_done.
// Backpressure: requests are held by the requester until if_gnt / ls_done; memory never stalls.
//
// Ports:
//   Clk1, Reset                 : clock, synchronous active-high reset
//   if_req/if_addr              : fetch request and word address (sampled in IDLE)
//   if_gnt/if_valid/if_data     : fetch grant pulse, data-valid pulse, registered fetched word
//   ls_req/ls_we/ls_base/ls_count/ls_wdata : vector burst request (sampled in IDLE)
//   ls_busy/ls_done/ls_rdata    : burst busy, completion pulse, assembled load vector
//   Addr/RD/WR/V/dataOut/DataIn : memory port; DataIn valid the cycle after RD
//
// Build option: VMEM_ZERO_FILL_EN -- when defined, ls_rdata is cleared at every load grant so
// lanes above ls_count read zero; otherwise those lanes keep their previous contents.
module vec_mem_seq
    import cvp14_pkg::*;
(
    input  logic                Clk1,
    input  logic                Reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [LANE_W-1:0]   if_data,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_base,
    input  logic [CNT_W-1:0]    ls_count,
    input  logic [VEC_W-1:0]    ls_wdata,
    output logic                ls_busy,
    output logic                ls_done,
    output logic [VEC_W-1:0]    ls_rdata,
    output logic [ADDR_W-1:0]   Addr,
    output logic                RD,
    output logic                WR,
    output logic                V,
    output logic [LANE_W-1:0]   dataOut,
    input  logic [LANE_W-1:0]   DataIn
);

    vmem_state_e        state_q,    state_d;
    gnt_e               last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   k_q,        k_d;        // lane of the strobe currently on the bus
    logic [CNT_W-1:0]   cnt_q,      cnt_d;      // last lane index of the burst
    logic [VEC_W-1:0]   wdata_q,    wdata_d;
    logic [VEC_W-1:0]   rdata_q,    rdata_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [LANE_W-1:0]  dout_q,     dout_d;
    logic [LANE_W-1:0]  if_data_q,  if_data_d;
    logic               rd_q,       rd_d;
    logic               wr_q,       wr_d;
    logic               v_q,        v_d;
    logic               if_gnt_q,   if_gnt_d;
    logic               if_valid_q, if_valid_d;
    logic               ls_busy_q,  ls_busy_d;
    logic               ls_done_q,  ls_done_d;

    logic               grant_vec;
    logic               grant_fetch;

    logic [VEC_W-1:0]   mux_vec;
    logic [CNT_W-1:0]   mux_sel;
    logic [LANE_W-1:0]  mux_lane;

    // Store data for the next WR strobe. At grant the vector has not been latched yet,
    // so the mux looks at the request input directly.
    vmem_lane_mux u_lane_mux (
        .vec_dat  (mux_vec),
        .sel      (mux_sel),
        .lane_dat (mux_lane)
    );

    // Round-robin: on a tie the vector port wins unless it was the last one granted.
    always_comb begin
        grant_vec   = ls_req && (!if_req || (last_gnt_q == GNT_FETCH));
        grant_fetch = if_req && !grant_vec;
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        addr_d     = '0;
        dout_d     = '0;
        if_data_d  = if_data_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        v_d        = 1'b0;
        if_gnt_d   = 1'b0;
        if_valid_d = 1'b0;
        ls_busy_d  = ls_busy_q;
        ls_done_d  = 1'b0;
        mux_vec    = wdata_q;
        mux_sel    = k_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (grant_vec) begin
                    last_gnt_d = GNT_VEC;
                    k_d        = '0;
                    cnt_d      = ls_count;
                    wdata_d    = ls_wdata;
                    addr_d     = ls_base;
                    v_d        = 1'b1;
                    ls_busy_d  = 1'b1;
                    if (ls_we) begin
                        state_d = LS_WR;
                        wr_d    = 1'b1;
                        mux_vec = ls_wdata;
                        mux_sel = '0;
                        dout_d  = mux_lane;
                    end else begin
                        state_d = LS_RD;
                        rd_d    = 1'b1;
`ifdef VMEM_ZERO_FILL_EN
                        rdata_d = '0;
`endif
                    end
                end else if (grant_fetch) begin
                    state_d    = IF_RD;
                    last_gnt_d = GNT_FETCH;
                    rd_d       = 1'b1;
                    addr_d     = if_addr;
                    if_gnt_d   = 1'b1;
                end
            end

            IF_RD: begin
                state_d = IF_CAP;
            end

            IF_CAP: begin
                if_data_d  = DataIn;
                if_valid_d = 1'b1;
                state_d    = IDLE;
            end

            LS_RD: begin
                // DataIn here answers the strobe of the previous cycle, i.e. lane k-1.
                if (k_q != '0) begin
                    rdata_d[int'(k_q - 1'b1) * LANE_W +: LANE_W] = DataIn;
                end
                if (k_q == cnt_q) begin
                    state_d = LS_CAP;
                end else begin
                    k_d    = k_q + 1'b1;
                    addr_d = addr_q + 1'b1;   // 16-bit wrap is intentional
                    rd_d   = 1'b1;
                    v_d    = 1'b1;
                end
            end

            LS_CAP: begin
                // Last strobe went out in the previous cycle; k is still that lane.
                rdata_d[int'(k_q) * LANE_W +: LANE_W] = DataIn;
                state_d   = DONE;
                ls_done_d = 1'b1;
            end

            LS_WR: begin
                if (k_q == cnt_q) begin
                    state_d   = DONE;
                    ls_done_d = 1'b1;
                end else begin
                    k_d    = k_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                    wr_d   = 1'b1;
                    v_d    = 1'b1;
                    dout_d = mux_lane;
                end
            end

            DONE: begin
                state_d   = IDLE;
                ls_busy_d = 1'b0;
            end

            default: begin
                state_d   = IDLE;
                ls_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_gnt_q <= GNT_FETCH;
            k_q        <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            if_data_q  <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            v_q        <= 1'b0;
            if_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            ls_busy_q  <= 1'b0;
            ls_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            if_data_q  <= if_data_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            v_q        <= v_d;
            if_gnt_q   <= if_gnt_d;
            if_valid_q <= if_valid_d;
            ls_busy_q  <= ls_busy_d;
            ls_done_q  <= ls_done_d;
        end
    end

    assign if_gnt   = if_gnt_q;
    assign if_valid = if_valid_q;
    assign if_data  = if_data_q;
    assign ls_busy  = ls_busy_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = rdata_q;
    assign Addr     = addr_q;
    assign RD       = rd_q;
    assign WR       = wr_q;
    assign V        = v_q;
    assign dataOut  = dout_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with a memory model and a strobe scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_vec_mem_seq;

    logic         Clk1 = 1'b0;
    logic         Reset;
    logic         if_req;
    logic [15:0]  if_addr;
    logic         if_gnt;
    logic         if_valid;
    logic [15:0]  if_data;
    logic         ls_req;
    logic         ls_we;
    logic [15:0]  ls_base;
    logic [3:0]   ls_count;
    logic [255:0] ls_wdata;
    logic         ls_busy;
    logic         ls_done;
    logic [255:0] ls_rdata;
    logic [15:0]  Addr;
    logic         RD;
    logic         WR;
    logic         V;
    logic [15:0]  dataOut;
    logic [15:0]  DataIn;

    vec_mem_seq dut (
        .Clk1     (Clk1),
        .Reset    (Reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_base  (ls_base),
        .ls_count (ls_count),
        .ls_wdata (ls_wdata),
        .ls_busy  (ls_busy),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .Addr     (Addr),
        .RD       (RD),
        .WR       (WR),
        .V        (V),
        .dataOut  (dataOut),
        .DataIn   (DataIn)
    );

    always #5 Clk1 = ~Clk1;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        v;
        logic [15:0] addr;
        logic [15:0] dat;
    } strobe_t;

    strobe_t      sb[$];
    strobe_t      mon_e;
    int           n_pass   = 0;
    int           n_chk    = 0;
    int           n_strobe = 0;
    int           n_done   = 0;
    int           n_ifv    = 0;
    logic         mon_en   = 1'b0;
    logic [15:0]  mem_a;
    logic [15:0]  last_wr_addr;
    logic [255:0] exp_rdata;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return (a == 16'h0040) ? 16'h1234 : 16'(16'hA000 + a);
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk1);
        #1;
    endtask

    task automatic push(input logic rd, input logic wr, input logic v,
                        input logic [15:0] addr, input logic [15:0] dat);
        strobe_t s;
        s.rd = rd; s.wr = wr; s.v = v; s.addr = addr; s.dat = dat;
        sb.push_back(s);
    endtask

    // Memory: a read strobe seen at an edge returns data during the next cycle.
    always begin
        @(posedge Clk1);
        if (RD === 1'b1) begin
            mem_a = Addr;
            #1 DataIn = mem_rd(mem_a);
        end
    end

    // Bus monitor: protocol invariants plus in-order strobe scoreboard.
    always @(negedge Clk1) begin
        if (mon_en) begin
            check("rd_wr_excl", RD & WR, 0);
            if (!WR) check("dout_zero_no_wr", dataOut, 0);
            if (RD || WR) begin
                n_strobe = n_strobe + 1;
                if (WR) last_wr_addr = Addr;
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("strobe", {RD, WR, V, Addr, dataOut}, mon_e);
                end
            end
            if (ls_done)  n_done = n_done + 1;
            if (if_valid) n_ifv  = n_ifv + 1;
        end
    end

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && ls_done !== 1'b1; i++) tick();
        check({tag, "_done_seen"}, ls_done, 1);
        tick();   // DONE -> IDLE
    endtask

    task automatic do_load(input string tag, input logic [15:0] base, input logic [3:0] cnt);
        int s0, d0;
        s0 = n_strobe;
        d0 = n_done;
`ifdef VMEM_ZERO_FILL_EN
        exp_rdata = '0;
`endif
        for (int k = 0; k <= int'(cnt); k++) begin
            push(1'b1, 1'b0, 1'b1, 16'(base + 16'(k)), 16'h0);
            exp_rdata[k*16 +: 16] = mem_rd(16'(base + 16'(k)));
        end
        ls_req = 1'b1; ls_we = 1'b0; ls_base = base; ls_count = cnt;
        tick();
        check({tag, "_busy"}, ls_busy, 1);
        ls_req = 1'b0;
        wait_done(tag);
        check({tag, "_rd_count"}, n_strobe - s0, int'(cnt) + 1);
        check({tag, "_done_once"}, n_done - d0, 1);
        check({tag, "_rdata"}, ls_rdata, exp_rdata);
    endtask

    task automatic do_store(input string tag, input logic [15:0] base, input logic [3:0] cnt,
                            input logic [255:0] wd);
        int s0;
        s0 = n_strobe;
        for (int k = 0; k <= int'(cnt); k++)
            push(1'b0, 1'b1, 1'b1, 16'(base + 16'(k)), wd[k*16 +: 16]);
        ls_req = 1'b1; ls_we = 1'b1; ls_base = base; ls_count = cnt; ls_wdata = wd;
        tick();
        check({tag, "_busy"}, ls_busy, 1);
        ls_req = 1'b0;
        wait_done(tag);
        check({tag, "_wr_count"}, n_strobe - s0, int'(cnt) + 1);
        check({tag, "_rdata_kept"}, ls_rdata, exp_rdata);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {if_gnt, if_valid, ls_busy, ls_done, RD, WR, V}, 0);
        check({tag, "_addr"}, Addr, 0);
        check({tag, "_dout"}, dataOut, 0);
        check({tag, "_if_data"}, if_data, 0);
        check({tag, "_rdata"}, ls_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] wd;
        logic [3:0]   gseq;
        int           ng, d0, v0;
        logic         busy_prev;

        Reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_base = '0; ls_count = '0; ls_wdata = '0; DataIn = '0;
        exp_rdata = '0;
        repeat (3) tick();
        check_all_zero("reset");
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Fetch 0x0040 -> 0x1234, gnt on cycle 1, valid on cycle 3.
        if_req = 1'b1; if_addr = 16'h0040;
        push(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
        tick();
        check("if_gnt_c1", if_gnt, 1);
        check("if_rd_c1", {RD, V, Addr}, {1'b1, 1'b0, 16'h0040});
        if_req = 1'b0;
        tick();
        check("if_gnt_pulse", if_gnt, 0);
        check("if_valid_c2", if_valid, 0);
        tick();
        check("if_valid_c3", if_valid, 1);
        check("if_data", if_data, 16'h1234);
        tick();
        check("if_valid_pulse", if_valid, 0);
        check("if_data_hold", if_data, 16'h1234);

        // Load 4 words at 0x0100.
        do_load("ld4", 16'h0100, 4'd3);
        check("ld4_lane0", ls_rdata[15:0],  16'hA100);
        check("ld4_lane3", ls_rdata[63:48], 16'hA103);

        // Full load then single-word load: upper lanes depend on zero-fill build option.
        do_load("ld16", 16'h0200, 4'd15);
        do_load("ld1", 16'h0300, 4'd0);
`ifdef VMEM_ZERO_FILL_EN
        check("ld1_upper", ls_rdata[255:16], 240'h0);
`else
        check("ld1_upper_lane15", ls_rdata[255:240], 16'hA20F);
`endif

        // Store across the address wrap.
        wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        wd[15:0] = 16'h0011; wd[31:16] = 16'h0022; wd[47:32] = 16'h0033;
        do_store("st3", 16'hFFFE, 4'd2, wd);
        check("st3_wrap_addr", last_wr_addr, 16'h0000);

        // Round-robin from reset with both requests held.
        Reset = 1'b1; tick(); tick(); Reset = 1'b0;
        exp_rdata = '0;
        check("arb_sb_empty", sb.size(), 0);
        for (int r = 0; r < 2; r++) begin
            push(1'b1, 1'b0, 1'b1, 16'h0400, 16'h0);
            push(1'b1, 1'b0, 1'b1, 16'h0401, 16'h0);
            push(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
        end
        if_req = 1'b1; if_addr = 16'h0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_base = 16'h0400; ls_count = 4'd1;
        ng = 0; gseq = '0; busy_prev = 1'b0;
        for (int i = 0; i < 80 && ng < 4; i++) begin
            tick();
            if (if_gnt) begin
                gseq[ng] = 1'b0; ng++;
            end else if (ls_busy && !busy_prev) begin
                gseq[ng] = 1'b1; ng++;
            end
            busy_prev = ls_busy;
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("arb_grants", ng, 4);
        check("arb_order", gseq, 4'b0101);
        repeat (4) tick();
        check("arb_if_data", if_data, 16'h1234);

        // Reset on the second word of an 8-word load.
        push(1'b1, 1'b0, 1'b1, 16'h0500, 16'h0);
        push(1'b1, 1'b0, 1'b1, 16'h0501, 16'h0);
        d0 = n_done; v0 = n_ifv;
        ls_req = 1'b1; ls_we = 1'b0; ls_base = 16'h0500; ls_count = 4'd7;
        tick();
        tick();
        check("abort_rd2", {RD, Addr}, {1'b1, 16'h0501});
        Reset = 1'b1;
        tick();
        check_all_zero("abort");
        Reset = 1'b0; ls_req = 1'b0;
        repeat (5) tick();
        check("abort_no_done", n_done - d0, 0);
        check("abort_no_ifvalid", n_ifv - v0, 0);
        check("abort_idle", {RD, WR, ls_busy}, 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
